huff_dict_loader: RTL and testbench
===================================

Name: huff_dict_loader

Overview:
Upstream stage of the Huffman decode block. It pops the dictionary header from the input byte FIFO and builds a code table of (char, length, code) entries. It raises dict_ready once the table is complete. It then answers single-cycle-registered lookups: for an accumulated code of a given length it returns the matching Char and a hit/miss flag to the decoder.

Parameters:
N_SYM, 16, maximum dictionary entries held
MAX_LEN, 16, maximum code length in bits; codes are carried right-aligned in MAX_LEN bits
CW, 5, width of the entry counter; must satisfy 2^CW > N_SYM

Ports:
clk  in  1  clock, rising edge
n_rst  in  1  asynchronous active-low reset
reload  in  1  one-cycle pulse; discard the table and re-read a header
empty  in  1  input FIFO empty
fifo_data  in  8  FIFO head byte (first-word-fall-through: valid whenever empty=0)
r_en  out  1  pop FIFO head this cycle
dict_ready  out  1  table loaded and valid
dict_err  out  1  malformed header; sticky until reload or reset
lk_valid  in  1  lookup request
lk_len  in  7  length of code under test (matches decoder code_len)
lk_code  in  MAX_LEN  code bits, right-aligned
lk_done  out  1  one-cycle pulse, one cycle after lk_valid
lk_hit  out  1  valid with lk_done; 1 if an entry matched
Char  out  8  matched symbol; valid with lk_done and lk_hit

Behaviour:
- Reset: state=S_CNT; r_en, dict_ready, dict_err, lk_done, lk_hit = 0; Char = 8'h00; entry count and all entry-valid bits = 0.
- Header format: byte0 = N. Then N records of 4 bytes each: char, len, code_hi, code_lo. Code = {code_hi, code_lo}, truncated to MAX_LEN.
- r_en is combinational: equals (state is a load state) && !empty. A byte is consumed on each cycle with r_en=1. While empty=1 the FSM stalls with no state change.
- FSM states and transitions:
  - S_CNT: pop N. N==0 or N>N_SYM -> S_ERR. Otherwise latch N, idx=0 -> S_CHAR.
  - S_CHAR: latch char -> S_LEN.
  - S_LEN: len==0 or len>MAX_LEN -> S_ERR. Otherwise latch -> S_CHI.
  - S_CHI: latch high byte -> S_CLO.
  - S_CLO: write entry[idx], set valid[idx]. If idx==N-1 -> S_READY, else idx++ -> S_CHAR.
  - S_READY: dict_ready=1, registered, asserted the cycle after the final pop. No further pops.
  - S_ERR: dict_err=1, dict_ready=0, no pops. Remaining header bytes stay in the FIFO.
- reload takes priority over every other event in every state: next cycle state=S_CNT, all valid bits cleared, dict_ready=0, dict_err=0. A byte popped in the same cycle as reload is discarded.
- Lookup is serviced only in S_READY:
  - An entry i matches when valid[i] && len[i]==lk_len && code[i]==lk_code (masked to len[i] bits).
  - Next cycle: lk_done=1, lk_hit=any match, Char=char of the lowest matching index.
  - On a miss, Char holds its previous value.
- lk_valid outside S_READY: lk_done=1, lk_hit=0 on the next cycle; the decoder treats this as a miss.
- Back-to-back lk_valid is allowed; throughput is one lookup per cycle.
- Duplicate codes are not an error; the lowest index wins.
- lk_len > MAX_LEN never matches.
- Mid-load reset or reload leaves no partial entries valid.

Decomposition:
- Shared package huff_pkg:
  - state enum dict_state_t {S_CNT, S_CHAR, S_LEN, S_CHI, S_CLO, S_READY, S_ERR}
  - struct dict_entry_t {char[7:0], len[6:0], code[MAX_LEN-1:0]}
  - constants HDR_BYTES_PER_ENTRY=4, MAX_LEN_DEFAULT=16
- One sub-module, huff_dict_match: a combinational parallel compare plus lowest-index priority encoder over the entry array, returning hit and index. The parent registers its outputs.

Test Plan:
- Load N=2: {'A', len 1, 0x0000}, {'B', len 2, 0x0002}, FIFO always non-empty -> exactly 9 pops. dict_ready rises the cycle after the 9th pop; dict_err stays 0.
- After that load: lookup len=2 code=0x2 -> next cycle lk_done=1, lk_hit=1, Char=0x42. Lookup len=2 code=0x3 -> lk_hit=0, Char still 0x42.
- Header N=0 -> one pop, then dict_err=1, r_en held 0, dict_ready=0. Header N=17 gives the same response. Entry with len=0 gives the same response after the 3rd pop.
- empty toggled every other cycle during the N=2 load -> identical table. r_en never asserted while empty=1.
- reload pulsed during S_CHI of entry 1 -> dict_ready=0. The next byte is treated as N. A fresh N=1 {'Z', len 3, 0x5} load then hits on len=3 code=0x5 with Char=0x5A.
- n_rst asserted mid-load, then a lookup -> lk_done with lk_hit=0. Duplicate entries {'X', 2, 0x1}, {'Y', 2, 0x1} then lookup len=2 code=0x1 -> Char=0x58.

Source files
------------

// File: rtl/huff_pkg.sv
// rtl/huff_pkg.sv - shared types and helpers for the Huffman dictionary loader
package huff_pkg;

    localparam int MAX_LEN_DEFAULT     = 16;
    localparam int HDR_BYTES_PER_ENTRY = 4;

    typedef enum logic [2:0] {
        S_CNT,
        S_CHAR,
        S_LEN,
        S_CHI,
        S_CLO,
        S_READY,
        S_ERR
    } dict_state_t;

    typedef struct packed {
        logic [7:0]                 chr;
        logic [6:0]                 len;
        logic [MAX_LEN_DEFAULT-1:0] code;
    } dict_entry_t;

    // Low 'len' bits set; lengths at or beyond the code width select every bit.
    function automatic logic [MAX_LEN_DEFAULT-1:0] len_mask(input logic [6:0] len);
        if (len >= 7'(MAX_LEN_DEFAULT)) begin
            return '1;
        end
        return (MAX_LEN_DEFAULT'(1) << len) - MAX_LEN_DEFAULT'(1);
    endfunction

endpackage

// File: rtl/huff_dict_match.sv
// rtl/huff_dict_match.sv - parallel code compare with lowest-index priority select
module huff_dict_match
    import huff_pkg::*;
#(
    parameter int N_SYM = 16,
    parameter int IW    = 4
) (
    input  dict_entry_t                i_entries [N_SYM],
    input  logic [N_SYM-1:0]           i_valid,
    input  logic [6:0]                 i_len,
    input  logic [MAX_LEN_DEFAULT-1:0] i_code,
    output logic                       o_hit,
    output logic [IW-1:0]              o_idx
);

    // Scan from the top down so the lowest matching index is the last writer.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int i = N_SYM - 1; i >= 0; i--) begin
            if (i_valid[i] && (i_entries[i].len == i_len) &&
                (((i_entries[i].code ^ i_code) & len_mask(i_entries[i].len)) == '0)) begin
                o_hit = 1'b1;
                o_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/huff_dict_loader.sv
// rtl/huff_dict_loader.sv - parses the dictionary header from the byte FIFO and serves code lookups
module huff_dict_loader
    import huff_pkg::*;
#(
    parameter int N_SYM   = 16,
    parameter int MAX_LEN = 16,
    parameter int CW      = 5
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               reload,
    input  logic               empty,
    input  logic [7:0]         fifo_data,
    output logic               r_en,
    output logic               dict_ready,
    output logic               dict_err,
    input  logic               lk_valid,
    input  logic [6:0]         lk_len,
    input  logic [MAX_LEN-1:0] lk_code,
    output logic               lk_done,
    output logic               lk_hit,
    output logic [7:0]         Char
);

    localparam int         IW         = (N_SYM > 1) ? $clog2(N_SYM) : 1;
    localparam logic [7:0] LP_N_SYM   = 8'(N_SYM);
    localparam logic [7:0] LP_MAX_LEN = 8'(MAX_LEN);

    dict_state_t      r_state;
    dict_state_t      w_next;
    logic [CW-1:0]    r_n;
    logic [CW-1:0]    r_idx;
    logic [7:0]       r_char;
    logic [6:0]       r_len;
    logic [7:0]       r_chi;
    dict_entry_t      r_entries [N_SYM];
    logic [N_SYM-1:0] r_valid;
    logic             r_lk_done;
    logic             r_lk_hit;
    logic [7:0]       r_char_out;
    logic             w_load;
    logic             w_hit;
    logic [IW-1:0]    w_idx;
    logic             w_serve;

    assign w_load     = (r_state == S_CNT) || (r_state == S_CHAR) || (r_state == S_LEN) ||
                        (r_state == S_CHI) || (r_state == S_CLO);
    assign r_en       = w_load && !empty;
    assign dict_ready = (r_state == S_READY);
    assign dict_err   = (r_state == S_ERR);
    assign lk_done    = r_lk_done;
    assign lk_hit     = r_lk_hit;
    assign Char       = r_char_out;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_CNT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (reload) begin
            w_next = S_CNT;
        end else if (r_en) begin
            case (r_state)
                S_CNT:   w_next = ((fifo_data == 8'd0) || (fifo_data > LP_N_SYM)) ? S_ERR : S_CHAR;
                S_CHAR:  w_next = S_LEN;
                S_LEN:   w_next = ((fifo_data == 8'd0) || (fifo_data > LP_MAX_LEN)) ? S_ERR : S_CHI;
                S_CHI:   w_next = S_CLO;
                S_CLO:   w_next = (r_idx == r_n - CW'(1)) ? S_READY : S_CHAR;
                default: w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_n     <= '0;
            r_idx   <= '0;
            r_char  <= '0;
            r_len   <= '0;
            r_chi   <= '0;
            r_valid <= '0;
        end else if (reload) begin
            r_valid <= '0;
            r_idx   <= '0;
        end else if (r_en) begin
            case (r_state)
                S_CNT: begin
                    r_n   <= fifo_data[CW-1:0];
                    r_idx <= '0;
                end
                S_CHAR: r_char <= fifo_data;
                S_LEN:  r_len  <= fifo_data[6:0];
                S_CHI:  r_chi  <= fifo_data;
                S_CLO: begin
                    r_valid[r_idx[IW-1:0]] <= 1'b1;
                    r_idx                  <= r_idx + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Entry payloads need no reset: nothing is visible until its valid bit is set.
    always_ff @(posedge clk) begin
        if (!reload && r_en && (r_state == S_CLO)) begin
            r_entries[r_idx[IW-1:0]] <= '{
                chr:  r_char,
                len:  r_len,
                code: MAX_LEN_DEFAULT'(MAX_LEN'({r_chi, fifo_data}))
            };
        end
    end

    huff_dict_match #(
        .N_SYM (N_SYM),
        .IW    (IW)
    ) u_match (
        .i_entries (r_entries),
        .i_valid   (r_valid),
        .i_len     (lk_len),
        .i_code    (MAX_LEN_DEFAULT'(lk_code)),
        .o_hit     (w_hit),
        .o_idx     (w_idx)
    );

    assign w_serve = lk_valid && (r_state == S_READY) && w_hit;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_lk_done  <= 1'b0;
            r_lk_hit   <= 1'b0;
            r_char_out <= 8'h00;
        end else begin
            r_lk_done <= lk_valid;
            r_lk_hit  <= w_serve;
            if (w_serve) begin
                r_char_out <= r_entries[w_idx].chr;
            end
        end
    end

endmodule

// File: tb/tb_huff_dict_loader.sv
// tb/tb_huff_dict_loader.sv - scoreboard bench for huff_dict_loader
module tb_huff_dict_loader;
    import huff_pkg::*;

    localparam int N_SYM_TB = 16;

    logic        clk = 1'b0;
    logic        n_rst, reload, empty, r_en, dict_ready, dict_err;
    logic        lk_valid, lk_done, lk_hit;
    logic [7:0]  fifo_data, Char;
    logic [6:0]  lk_len;
    logic [15:0] lk_code;

    always #5 clk = ~clk;

    huff_dict_loader #(.N_SYM(16), .MAX_LEN(16), .CW(5)) dut (
        .clk(clk), .n_rst(n_rst), .reload(reload), .empty(empty), .fifo_data(fifo_data),
        .r_en(r_en), .dict_ready(dict_ready), .dict_err(dict_err), .lk_valid(lk_valid),
        .lk_len(lk_len), .lk_code(lk_code), .lk_done(lk_done), .lk_hit(lk_hit), .Char(Char)
    );

    typedef struct { int ch; int len; int code; } rec_t;
    typedef struct { bit hit; int ch; } resp_t;

    rec_t       m_tab[$];
    resp_t      exp_q[$];
    logic [7:0] fifo_q[$];
    bit         m_ready, m_err_exp, pend_pop, tog_mode, tog_phase;
    int         m_char, m_pops, pops, viol, checks, errors;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int code_mask(input int len);
        return (len >= 16) ? 32'hFFFF : ((1 << len) - 1);
    endfunction

    // Header rules: count byte, then 4-byte records; a bad count or length stops the load.
    function automatic void model_parse(input logic [7:0] b[$]);
        int   n;
        int   base;
        int   len;
        rec_t r;
        n = int'(b[0]);
        m_tab.delete();
        m_err_exp = 1'b0;
        if (n == 0 || n > N_SYM_TB) begin
            m_pops = 1;
            m_err_exp = 1'b1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            base = 1 + HDR_BYTES_PER_ENTRY * i;
            len  = int'(b[base+1]);
            if (len == 0 || len > 16) begin
                m_pops = base + 2;
                m_err_exp = 1'b1;
                m_tab.delete();
                return;
            end
            r.ch   = int'(b[base]);
            r.len  = len;
            r.code = (int'(b[base+2]) * 256 + int'(b[base+3])) & 32'hFFFF;
            m_tab.push_back(r);
        end
        m_pops = 1 + HDR_BYTES_PER_ENTRY * n;
    endfunction

    task automatic tick();
        logic [7:0] d;
        @(posedge clk);
        @(negedge clk);
        if (pend_pop) begin
            if (fifo_q.size() > 0) d = fifo_q.pop_front();
            pops++;
        end
        reload    = 1'b0;
        lk_valid  = 1'b0;
        tog_phase = !tog_phase;
        empty     = (fifo_q.size() == 0) || (tog_mode && tog_phase);
        fifo_data = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
        #1;
        pend_pop = r_en;
        if (r_en && empty) viol++;
    endtask

    task automatic lookup(input int len, input int code);
        resp_t r;
        r.hit = 1'b0;
        r.ch  = m_char;
        if (m_ready) begin
            for (int i = 0; i < m_tab.size(); i++) begin
                if (!r.hit && m_tab[i].len == len &&
                    ((m_tab[i].code ^ code) & code_mask(m_tab[i].len)) == 0) begin
                    r.hit = 1'b1;
                    r.ch  = m_tab[i].ch;
                end
            end
        end
        m_char = r.ch;
        exp_q.push_back(r);
        lk_valid = 1'b1;
        lk_len   = 7'(len);
        lk_code  = 16'(code);
        tick();
    endtask

    task automatic do_reload(input string name);
        reload = 1'b1;
        tick();
        m_ready = 1'b0;
        m_tab.delete();
        chk({name, "_reload_rdy"}, int'(dict_ready), 0);
        chk({name, "_reload_err"}, int'(dict_err), 0);
    endtask

    task automatic flush_reload(input string name);
        fifo_q.delete();
        do_reload(name);
    endtask

    task automatic run_load(input string name, input logic [7:0] b[$], input bit tog);
        int guard;
        guard = 0;
        model_parse(b);
        pops = 0;
        tog_mode = tog;
        foreach (b[i]) fifo_q.push_back(b[i]);
        fifo_q.push_back(8'hEE);
        fifo_q.push_back(8'hEE);
        while (pops < m_pops - 1 && guard < 400) begin tick(); guard++; end
        chk({name, "_early_rdy"}, int'(dict_ready), 0);
        chk({name, "_early_err"}, int'(dict_err), 0);
        while (pops < m_pops && guard < 400) begin tick(); guard++; end
        chk({name, "_pops"}, pops, m_pops);
        chk({name, "_rdy"}, int'(dict_ready), int'(!m_err_exp));
        chk({name, "_err"}, int'(dict_err), int'(m_err_exp));
        repeat (3) tick();
        chk({name, "_no_extra_pop"}, pops, m_pops);
        chk({name, "_rdy_hold"}, int'(dict_ready), int'(!m_err_exp));
        chk({name, "_ren_idle"}, int'(r_en), 0);
        m_ready  = !m_err_exp;
        tog_mode = 1'b0;
    endtask

    initial begin : monitor
        resp_t r;
        forever begin
            @(negedge clk);
            if (n_rst === 1'b1 && lk_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_lk_done: got lk_done=1 expected no response");
                end else begin
                    r = exp_q.pop_front();
                    chk("lk_hit", int'(lk_hit), int'(r.hit));
                    chk("Char", int'(Char), r.ch);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [7:0] ab[$];
        logic [7:0] b[$];
        int         n, len, code, k;
        rec_t       rr;

        ab = '{8'd2, 8'h41, 8'd1, 8'h00, 8'h00, 8'h42, 8'd2, 8'h00, 8'h02};
        n_rst = 1'b0; reload = 1'b0; lk_valid = 1'b0; empty = 1'b1;
        fifo_data = 8'h00; lk_len = '0; lk_code = '0;
        pend_pop = 1'b0; tog_mode = 1'b0; tog_phase = 1'b0;
        m_ready = 1'b0; m_char = 0; viol = 0; checks = 0; errors = 0;
        repeat (3) tick();
        chk("rst_ren", int'(r_en), 0);
        chk("rst_rdy", int'(dict_ready), 0);
        chk("rst_err", int'(dict_err), 0);
        chk("rst_done", int'(lk_done), 0);
        chk("rst_hit", int'(lk_hit), 0);
        chk("rst_char", int'(Char), 0);
        n_rst = 1'b1;
        tick();

        run_load("ab", ab, 1'b0);
        lookup(2, 2);
        lookup(2, 3);
        lookup(1, 0);
        lookup(17, 0);

        flush_reload("n0");
        b = '{8'd0, 8'h11};
        run_load("n0", b, 1'b0);
        lookup(1, 0);
        flush_reload("n17");
        b = '{8'd17, 8'h11};
        run_load("n17", b, 1'b0);
        flush_reload("len0");
        b = '{8'd1, 8'h43, 8'd0, 8'h00, 8'h00};
        run_load("len0", b, 1'b0);
        lookup(1, 0);

        flush_reload("tog");
        run_load("tog", ab, 1'b1);
        lookup(1, 0);
        lookup(2, 2);
        lookup(2, 0);

        // Reload lands while the code_hi byte of entry 1 is being popped.
        flush_reload("mid");
        pops = 0;
        for (int i = 0; i < 8; i++) fifo_q.push_back(ab[i]);
        k = 0;
        while (pops < 7 && k < 100) begin tick(); k++; end
        chk("mid_pops", pops, 7);
        do_reload("mid");
        chk("mid_ren", int'(r_en), 0);
        lookup(1, 0);
        b = '{8'd1, 8'h5A, 8'd3, 8'h00, 8'h05};
        run_load("z", b, 1'b0);
        lookup(3, 5);
        lookup(3, 4);

        flush_reload("rst");
        pops = 0;
        foreach (ab[i]) fifo_q.push_back(ab[i]);
        k = 0;
        while (pops < 4 && k < 100) begin tick(); k++; end
        n_rst = 1'b0;
        fifo_q.delete();
        empty = 1'b1;
        pend_pop = 1'b0;
        m_ready = 1'b0; m_tab.delete(); m_char = 0;
        repeat (2) tick();
        chk("rst2_rdy", int'(dict_ready), 0);
        chk("rst2_char", int'(Char), 0);
        chk("rst2_ren", int'(r_en), 0);
        n_rst = 1'b1;
        tick();
        lookup(1, 0);
        b = '{8'd2, 8'h58, 8'd2, 8'h00, 8'h01, 8'h59, 8'd2, 8'h00, 8'h01};
        run_load("dup", b, 1'b0);
        lookup(2, 1);

        for (int t = 0; t < 6; t++) begin
            flush_reload("rand");
            b.delete();
            n = $urandom_range(1, 16);
            b.push_back(8'(n));
            for (int i = 0; i < n; i++) begin
                if (i > 0 && $urandom_range(0, 3) == 0) begin
                    k    = 1 + HDR_BYTES_PER_ENTRY * $urandom_range(0, i - 1);
                    len  = int'(b[k+1]);
                    code = int'(b[k+2]) * 256 + int'(b[k+3]);
                end else begin
                    len  = $urandom_range(1, 16);
                    code = int'($urandom) & code_mask(len);
                end
                if (t == 5 && i == n - 1) len = 17 + $urandom_range(0, 50);
                b.push_back(8'($urandom_range(0, 255)));
                b.push_back(8'(len));
                b.push_back(8'(code >> 8));
                b.push_back(8'(code));
            end
            run_load("rand", b, t[0]);
            for (int q = 0; q < 24; q++) begin
                if (m_tab.size() > 0 && $urandom_range(0, 1) == 1) begin
                    rr = m_tab[$urandom_range(0, m_tab.size() - 1)];
                    lookup(rr.len, rr.code);
                end else begin
                    len  = $urandom_range(1, 20);
                    code = int'($urandom) & code_mask(len);
                    lookup(len, code);
                end
                if ($urandom_range(0, 3) == 0) tick();
            end
        end

        repeat (4) tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("ren_while_empty", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
